guess_sequencer: RTL

Control stage directly upstream of the red/white peg comparator. Holds the secret code, accepts one player guess at a time, and walks the comparator through the four code slots: clears it, drives slot index and slot colour with compare enable for four cycles, then captures the resulting red/white peg counts. Also tracks turns used and declares win or lose for the round.

---
 rtl/guess_sequencer_if.sv | 40 ++++
 rtl/guess_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/guess_sequencer_if.sv
// Bundle between the guess sequencer and its surroundings:
// player controls, comparator drive and round status.
interface guess_sequencer_if #(
  parameter int TURN_W = 4
);
  logic              load_code;
  logic [11:0]       code_in;
  logic              start;
  logic [11:0]       guess_in;
  logic [2:0]        red_in;
  logic [2:0]        white_in;
  logic              compare_clr_n;
  logic              compareEn;
  logic [1:0]        compare_i;
  logic [2:0]        curr_code;
  logic [11:0]       guess;
  logic              busy;
  logic              result_valid;
  logic [2:0]        red_out;
  logic [2:0]        white_out;
  logic [TURN_W-1:0] turns_used;
  logic              win;
  logic              lose;

  modport master (
    output load_code, code_in, start, guess_in,
    output red_in, white_in,
    input  compare_clr_n, compareEn, compare_i,
    input  curr_code, guess, busy, result_valid,
    input  red_out, white_out, turns_used, win, lose
  );

  modport slave (
    input  load_code, code_in, start, guess_in,
    input  red_in, white_in,
    output compare_clr_n, compareEn, compare_i,
    output curr_code, guess, busy, result_valid,
    output red_out, white_out, turns_used, win, lose
  );
endinterface

// File: rtl/guess_sequencer.sv
// Round controller ahead of the peg comparator: clears it, walks
// the four slots, captures peg counts and tracks win/lose.
module guess_sequencer #(
  parameter int MAX_TURNS = 10,
  parameter int TURN_W    = 4
) (
  input logic              clock,
  input logic              resetn,
  guess_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, COMPARE, SETTLE, REPORT, GAME_OVER
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [11:0]       code_q, code_d;
  logic              loaded_q, loaded_d;
  logic [11:0]       guess_q, guess_d;
  logic [2:0]        red_q, red_d;
  logic [2:0]        white_q, white_d;
  logic [TURN_W-1:0] turns_q, turns_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              en_q, en_d;
  logic [1:0]        ci_q, ci_d;
  logic [2:0]        cc_q, cc_d;
  logic              clr_n_q, clr_n_d;

  function automatic logic [2:0] slot(
    input logic [11:0] c,
    input logic [1:0]  i
  );
    logic [2:0] s;
    unique case (i)
      2'd0: s = c[2:0];
      2'd1: s = c[5:3];
      2'd2: s = c[8:6];
      2'd3: s = c[11:9];
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    code_d   = code_q;
    loaded_d = loaded_q;
    guess_d  = guess_q;
    red_d    = red_q;
    white_d  = white_q;
    turns_d  = turns_q;
    win_d    = win_q;
    lose_d   = lose_q;
    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (bus.load_code) begin
          code_d   = bus.code_in;
          loaded_d = 1'b1;
          turns_d  = '0;
          win_d    = 1'b0;
          lose_d   = 1'b0;
          state_d  = IDLE;
        end else if (state_q == IDLE && bus.start && loaded_q) begin
          guess_d = bus.guess_in;
          idx_d   = 2'd0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        idx_d   = 2'd0;
        state_d = COMPARE;
      end
      COMPARE: begin
        if (idx_q == 2'd3) state_d = SETTLE;
        else idx_d = idx_q + 2'd1;
      end
      SETTLE: begin
        red_d   = bus.red_in;
        white_d = bus.white_in;
        state_d = REPORT;
      end
      REPORT: begin
        if (turns_q != TURN_W'(MAX_TURNS))
          turns_d = turns_q + TURN_W'(1);
        if (red_q == 3'd4) begin
          win_d   = 1'b1;
          state_d = GAME_OVER;
        end else if (turns_q + TURN_W'(1) == TURN_W'(MAX_TURNS)) begin
          lose_d  = 1'b1;
          state_d = GAME_OVER;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they land in registers.
  always_comb begin
    busy_d  = state_d inside {CLEAR, COMPARE, SETTLE, REPORT};
    rv_d    = state_d == REPORT;
    en_d    = state_d == COMPARE;
    ci_d    = en_d ? idx_d : 2'd0;
    cc_d    = en_d ? slot(code_q, idx_d) : 3'd0;
    clr_n_d = state_d != CLEAR;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      code_q   <= '0;
      loaded_q <= 1'b0;
      guess_q  <= '0;
      red_q    <= '0;
      white_q  <= '0;
      turns_q  <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      en_q     <= 1'b0;
      ci_q     <= 2'd0;
      cc_q     <= 3'd0;
      clr_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      loaded_q <= loaded_d;
      guess_q  <= guess_d;
      red_q    <= red_d;
      white_q  <= white_d;
      turns_q  <= turns_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      en_q     <= en_d;
      ci_q     <= ci_d;
      cc_q     <= cc_d;
      clr_n_q  <= clr_n_d;
    end
  end

  assign bus.compare_clr_n = clr_n_q;
  assign bus.compareEn     = en_q;
  assign bus.compare_i     = ci_q;
  assign bus.curr_code     = cc_q;
  assign bus.guess         = guess_q;
  assign bus.busy          = busy_q;
  assign bus.result_valid  = rv_q;
  assign bus.red_out       = red_q;
  assign bus.white_out     = white_q;
  assign bus.turns_used    = turns_q;
  assign bus.win           = win_q;
  assign bus.lose          = lose_q;

endmodule
